multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Moore-style control FSM that sequences the 8-bit multicycle MIPS datapath: byte-wise instruction fetch, decode, and execution of lb, sb, R-type, beq, j and (optionally) addi. Consumes the datapath's `op`, `funct` and `zero`; drives every datapath control input, plus a state/retire observation port for verification.

## Interface
- No parameters; the ISA encodings below are fixed.
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `op` in 6: instr[31:26] from the datapath.
- `funct` in 6: instr[5:0].
- `zero` in 1: ALU zero flag.
- `pcen` out 1: PC load enable, equal to `pcwrite | (branch & zero)`.
- `iord` out 1: 0 selects PC as the address, 1 selects `aluout`.
- `memwrite` out 1: memory write strobe.
- `irwrite` out 4: one-hot instruction byte enable.
- `regdst` out 1: 0 selects rt, 1 selects rd.
- `memtoreg` out 1: 0 selects `aluout`, 1 selects the memory data flop.
- `regwrite` out 1: register file write.
- `alusrca` out 1: 0 selects PC, 1 selects A.
- `alusrcb` out 2: 00 B, 01 constant 1, 10 imm, 11 imm×4.
- `alucont` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `pcsource` out 2: 00 `aluout`, 01 `aluout_flop`, 10 jump imm×4.
- `state` out 4: current state encoding, for debug and verification.
- `instr_done` out 1: one-cycle pulse in the final state of every instruction.

## Operation
- Opcodes:
  - lb 100000, sb 101000, R-type 000000, beq 000100, j 000010, addi 001000.
  - R-type funct: add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - Any other funct gives `alucont` 010.
- State encodings: FETCH1 0, FETCH2 1, FETCH3 2, FETCH4 3, DECODE 4, MEMADR 5, LBRD 6, LBWR 7, SBWR 8, RTYPEEX 9, RTYPEWR 10, BEQEX 11, JEX 12, ADDIEX 13, ADDIWR 14.
- Unlisted outputs are 0 in each state.
- FETCHn (n=1..4):
  - `irwrite` = 1<<(n-1); `iord`=0; `alusrca`=0; `alusrcb`=01; `alucont`=add; `pcsource`=00; `pcwrite`=1.
  - FETCHn advances to FETCHn+1; FETCH4 goes to DECODE.
- DECODE: `alusrca`=0, `alusrcb`=11, add; this computes the branch target into `aluout_flop`. Next state by `op`:
  - lb/sb go to MEMADR.
  - R-type goes to RTYPEEX.
  - beq goes to BEQEX.
  - j goes to JEX.
  - addi goes to ADDIEX.
  - Anything else goes to FETCH1 with no writes.
- MEMADR: `alusrca`=1, `alusrcb`=10, add. Next is LBRD for lb, SBWR for sb.
- LBRD: holds the MEMADR ALU controls, `iord`=1.
- LBWR: holds the LBRD controls, `memtoreg`=1, `regdst`=0, `regwrite`=1, `instr_done`=1.
- SBWR: holds the MEMADR ALU controls, `iord`=1, `memwrite`=1, `instr_done`=1.
- RTYPEEX and RTYPEWR: `alusrca`=1, `alusrcb`=00, `alucont` from funct in both states, because the register write data is the combinational `aluout`. RTYPEWR adds `regdst`=1, `regwrite`=1, `instr_done`=1.
- BEQEX: `alusrca`=1, `alusrcb`=00, sub, `pcsource`=01, `branch`=1, `instr_done`=1.
- JEX: `pcsource`=10, `pcwrite`=1, `instr_done`=1.
- ADDIEX / ADDIWR: `alusrca`=1, `alusrcb`=10, add in both states. ADDIWR adds `regdst`=0, `regwrite`=1, `instr_done`=1.
- All terminal states (LBWR, SBWR, RTYPEWR, BEQEX, JEX, ADDIWR) return to FETCH1.
- Undefined state codes 13–15 (or 15 alone when addi is compiled in) recover to FETCH1.

## Timing
- Reset low forces state FETCH1 immediately (asynchronous).
- While reset is low, `pcen`, `memwrite`, `irwrite`, `regwrite` and `instr_done` are forced to 0. Other outputs take their FETCH1 values.
- The first fetch write occurs on the first rising edge after reset deasserts.
- Reset asserted mid-instruction aborts it; no partial register or memory write occurs after assertion.
- Cycle counts per instruction: lb 8, sb 7, R-type 7, addi 7, beq 6, j 6, illegal 5.
- `pcen` is combinational on `zero` only in BEQEX. All other outputs are pure functions of state, plus `funct` in R-type states.
- `instr_done` is high for exactly one cycle per retired instruction and is never high for illegal opcodes.

## Configuration
- `MULTICYCLE_ADDI_EN` defined: ADDIEX and ADDIWR exist, and op 001000 executes addi.
- `MULTICYCLE_ADDI_EN` undefined:
  - op 001000 is illegal and goes DECODE to FETCH1.
  - State codes 13–15 are unreachable and recover to FETCH1.

## Test plan
- Reset low for 3 cycles, release: `state`=0 and all write enables 0 during reset. First edge after release gives `irwrite`=0001, `pcen`=1; `state` steps 0→1→2→3→4.
- op=000000, funct=100010: `state` sequence 4→9→10→0. `alucont`=110 in states 9 and 10. `regdst`=1 and `regwrite`=1 only in 10; `instr_done` pulses once.
- op=000100 with `zero`=1, then again with `zero`=0: in BEQEX `pcsource`=01 and `alucont`=110. `pcen`=1 in the first case, 0 in the second.
- op=100000, then op=101000: lb passes 5→6→7 with `iord`=1 and `regwrite` only in 7. sb passes 5→8 with `memwrite`=1 for exactly one cycle.
- op=001000 with the macro defined: 13→14 and `regwrite` in 14. Without the macro: 4→0 with no writes. op=111111 returns 4→0 with `instr_done`=0.
- Assert reset during RTYPEEX: `state`=0 immediately and `regwrite` never asserts for that instruction.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and the 8-bit MIPS datapath.
// The controller (master) drives every datapath control plus the state/retire
// observation signals; the datapath (slave) returns op, funct and zero.
interface multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       iord;
  logic       memwrite;
  logic [3:0] irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucont;
  logic [1:0] pcsource;
  logic [3:0] state;
  logic       instr_done;

  modport master (
    input  op, funct, zero,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, alucont, pcsource, state, instr_done
  );

  modport slave (
    output op, funct, zero,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, alucont, pcsource, state, instr_done
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the 8-bit multicycle MIPS datapath: four byte-wise
// fetch cycles, decode, then lb / sb / R-type / beq / j execution.
// Define MULTICYCLE_ADDI_EN to add the ADDIEX/ADDIWR states and the addi opcode.
// Control outputs are registered alongside the state (loaded with the values of
// the state being entered); only pcen (zero in BEQEX) and alucont (funct in the
// R-type states) carry a combinational input term. Write strobes are gated by
// the asynchronous active-low reset so nothing writes while it is held.
module multicycle_controller (
  input  logic                       clk,
  input  logic                       reset,
  multicycle_controller_if.master    bus
);

  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12,
    ADDIEX  = 4'd13,
    ADDIWR  = 4'd14
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Full control word held in a register next to the state.
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic [3:0] irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucont;
    logic [1:0] pcsource;
    logic       pcwrite;
    logic       branch;
    logic       instr_done;
  } ctrl_t;

  state_t state_reg;
  ctrl_t  ctrl_reg;
  logic   rtype_state;

  // Successor of state s given the current opcode.
  function automatic state_t next_state(input state_t s, input logic [5:0] op);
    state_t n;
    n = FETCH1;
    case (s)
      FETCH1:  n = FETCH2;
      FETCH2:  n = FETCH3;
      FETCH3:  n = FETCH4;
      FETCH4:  n = DECODE;
      DECODE: begin
        case (op)
          OP_LB, OP_SB: n = MEMADR;
          OP_RTYPE:     n = RTYPEEX;
          OP_BEQ:       n = BEQEX;
          OP_J:         n = JEX;
`ifdef MULTICYCLE_ADDI_EN
          OP_ADDI:      n = ADDIEX;
`endif
          default:      n = FETCH1;
        endcase
      end
      MEMADR:  n = (op == OP_SB) ? SBWR : LBRD;
      LBRD:    n = LBWR;
      RTYPEEX: n = RTYPEWR;
`ifdef MULTICYCLE_ADDI_EN
      ADDIEX:  n = ADDIWR;
`endif
      // Terminal states and unused codes all go back to fetch.
      default: n = FETCH1;
    endcase
    return n;
  endfunction

  // Moore control word for state s; anything not set here stays 0.
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        c.irwrite  = 4'b0001 << s[1:0];
        c.alusrcb  = 2'b01;
        c.alucont  = ALU_ADD;
        c.pcwrite  = 1'b1;
      end
      DECODE: begin
        c.alusrcb  = 2'b11;
        c.alucont  = ALU_ADD;
      end
      MEMADR: begin
        c.alusrca  = 1'b1;
        c.alusrcb  = 2'b10;
        c.alucont  = ALU_ADD;
      end
      LBRD: begin
        c.alusrca  = 1'b1;
        c.alusrcb  = 2'b10;
        c.alucont  = ALU_ADD;
        c.iord     = 1'b1;
      end
      LBWR: begin
        c.alusrca  = 1'b1;
        c.alusrcb  = 2'b10;
        c.alucont  = ALU_ADD;
        c.iord     = 1'b1;
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
        c.instr_done = 1'b1;
      end
      SBWR: begin
        c.alusrca  = 1'b1;
        c.alusrcb  = 2'b10;
        c.alucont  = ALU_ADD;
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
        c.instr_done = 1'b1;
      end
      RTYPEEX: begin
        c.alusrca  = 1'b1;
      end
      RTYPEWR: begin
        c.alusrca  = 1'b1;
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
        c.instr_done = 1'b1;
      end
      BEQEX: begin
        c.alusrca  = 1'b1;
        c.alucont  = ALU_SUB;
        c.pcsource = 2'b01;
        c.branch   = 1'b1;
        c.instr_done = 1'b1;
      end
      JEX: begin
        c.pcsource = 2'b10;
        c.pcwrite  = 1'b1;
        c.instr_done = 1'b1;
      end
`ifdef MULTICYCLE_ADDI_EN
      ADDIEX: begin
        c.alusrca  = 1'b1;
        c.alusrcb  = 2'b10;
        c.alucont  = ALU_ADD;
      end
      ADDIWR: begin
        c.alusrca  = 1'b1;
        c.alusrcb  = 2'b10;
        c.alucont  = ALU_ADD;
        c.regwrite = 1'b1;
        c.instr_done = 1'b1;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  // R-type ALU operation from the function field; unknown funct adds.
  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    logic [2:0] a;
    case (f)
      6'b100000: a = ALU_ADD;
      6'b100010: a = ALU_SUB;
      6'b100100: a = ALU_AND;
      6'b100101: a = ALU_OR;
      6'b101010: a = ALU_SLT;
      default:   a = ALU_ADD;
    endcase
    return a;
  endfunction

  // State register and registered control word; reset parks in FETCH1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= FETCH1;
      ctrl_reg  <= ctrl_for(FETCH1);
    end else begin
      state_reg <= next_state(state_reg, bus.op);
      ctrl_reg  <= ctrl_for(next_state(state_reg, bus.op));
    end
  end

  assign rtype_state = (state_reg == RTYPEEX) || (state_reg == RTYPEWR);

  // Write strobes are suppressed for as long as reset is held low.
  assign bus.pcen       = reset & (ctrl_reg.pcwrite | (ctrl_reg.branch & bus.zero));
  assign bus.memwrite   = reset & ctrl_reg.memwrite;
  assign bus.irwrite    = reset ? ctrl_reg.irwrite : 4'b0000;
  assign bus.regwrite   = reset & ctrl_reg.regwrite;
  assign bus.instr_done = reset & ctrl_reg.instr_done;

  assign bus.iord     = ctrl_reg.iord;
  assign bus.regdst   = ctrl_reg.regdst;
  assign bus.memtoreg = ctrl_reg.memtoreg;
  assign bus.alusrca  = ctrl_reg.alusrca;
  assign bus.alusrcb  = ctrl_reg.alusrcb;
  assign bus.alucont  = rtype_state ? funct_alu(bus.funct) : ctrl_reg.alucont;
  assign bus.pcsource = ctrl_reg.pcsource;
  assign bus.state    = state_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller. The reference model describes
// each instruction as a class plus a cycle index and derives every expected
// output from that (fetch cycles, decode, execute, last cycle).
// Honours MULTICYCLE_ADDI_EN the same way as the design.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  multicycle_controller_if bus();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int vectors = 0;
  int miscompares = 0;

  localparam int C_LB = 0, C_SB = 1, C_R = 2, C_BEQ = 3, C_J = 4, C_ADDI = 5, C_ILL = 6;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int classify(input logic [5:0] op);
    case (op)
      6'b100000: return C_LB;
      6'b101000: return C_SB;
      6'b000000: return C_R;
      6'b000100: return C_BEQ;
      6'b000010: return C_J;
`ifdef MULTICYCLE_ADDI_EN
      6'b001000: return C_ADDI;
`endif
      default:   return C_ILL;
    endcase
  endfunction

  function automatic int instr_len(input int cls);
    case (cls)
      C_LB:              return 8;
      C_SB, C_R, C_ADDI: return 7;
      C_BEQ, C_J:        return 6;
      default:           return 5;
    endcase
  endfunction

  // State code visited at cycle k of an instruction of class cls.
  function automatic int exp_state(input int cls, input int k);
    if (k < 5) return k;
    case (cls)
      C_LB:    return 5 + (k - 5);
      C_SB:    return (k == 5) ? 5 : 8;
      C_R:     return (k == 5) ? 9 : 10;
      C_BEQ:   return 11;
      C_J:     return 12;
      C_ADDI:  return (k == 5) ? 13 : 14;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] ref_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Compare every output against the model for cycle k of class cls.
  task automatic check_cycle(input int cls, input int k, input logic [5:0] f, input logic z);
    bit fetch, dec, exec, last, mem_like;
    logic [3:0] one;
    logic [3:0] ir_e;
    logic [1:0] srcb_e, pcs_e;
    logic [2:0] alu_e;
    string s;
    one = 4'b0001;
    fetch = (k < 4);
    dec = (k == 4);
    exec = (k >= 5);
    last = (k == instr_len(cls) - 1);
    mem_like = (cls == C_LB) || (cls == C_SB) || (cls == C_ADDI);
    ir_e = fetch ? (one << k) : 4'b0000;
    srcb_e = fetch ? 2'b01 : dec ? 2'b11 : mem_like ? 2'b10 : 2'b00;
    if (!exec)              alu_e = 3'b010;
    else if (cls == C_R)    alu_e = ref_alu(f);
    else if (cls == C_BEQ)  alu_e = 3'b110;
    else if (cls == C_J)    alu_e = 3'b000;
    else                    alu_e = 3'b010;
    pcs_e = (last && cls == C_BEQ) ? 2'b01 : (last && cls == C_J) ? 2'b10 : 2'b00;
    s = $sformatf("c%0d k%0d", cls, k);
    check_vec({s, " state"},    32'(bus.state),      32'(exp_state(cls, k)));
    check_vec({s, " irwrite"},  32'(bus.irwrite),    32'(ir_e));
    check_vec({s, " pcen"},     32'(bus.pcen),
              32'(fetch || (last && cls == C_J) || (last && cls == C_BEQ && z)));
    check_vec({s, " memwrite"}, 32'(bus.memwrite),   32'(last && cls == C_SB));
    check_vec({s, " regwrite"}, 32'(bus.regwrite),
              32'(last && (cls == C_LB || cls == C_R || cls == C_ADDI)));
    check_vec({s, " done"},     32'(bus.instr_done), 32'(last && cls != C_ILL));
    check_vec({s, " iord"},     32'(bus.iord),
              32'((cls == C_LB && k >= 6) || (cls == C_SB && k == 6)));
    check_vec({s, " memtoreg"}, 32'(bus.memtoreg),   32'(last && cls == C_LB));
    check_vec({s, " regdst"},   32'(bus.regdst),     32'(last && cls == C_R));
    check_vec({s, " alusrca"},  32'(bus.alusrca),    32'(exec && cls != C_J));
    check_vec({s, " alusrcb"},  32'(bus.alusrcb),    32'(srcb_e));
    check_vec({s, " alucont"},  32'(bus.alucont),    32'(alu_e));
    check_vec({s, " pcsource"}, 32'(bus.pcsource),   32'(pcs_e));
  endtask

  // Run one instruction from FETCH1; entered and left just after a falling edge.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic z);
    int cls;
    int done_cnt;
    cls = classify(op);
    bus.op = op;
    bus.funct = f;
    bus.zero = z;
    done_cnt = 0;
    for (int k = 0; k < instr_len(cls); k++) begin
      #1;
      check_cycle(cls, k, f, z);
      if (bus.instr_done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    #1;
    check_vec("back to fetch", 32'(bus.state), 32'd0);
    check_vec("retire count", 32'(done_cnt), (cls == C_ILL) ? 32'd0 : 32'd1);
    $display("instr op=%b funct=%b zero=%0b class=%0d cycles=%0d", op, f, z, cls, instr_len(cls));
  endtask

  // R-type aborted by reset while in RTYPEEX.
  task automatic abort_rtype(input logic [5:0] f);
    bus.op = 6'b000000;
    bus.funct = f;
    bus.zero = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      check_cycle(C_R, k, f, 1'b0);
      if (k < 5) @(negedge clk);
    end
    reset = 1'b0;
    #1;
    check_vec("abort state", 32'(bus.state), 32'd0);
    check_vec("abort regwrite", 32'(bus.regwrite), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check_vec("abort hold state", 32'(bus.state), 32'd0);
      check_vec("abort hold regwrite", 32'(bus.regwrite), 32'd0);
      check_vec("abort hold done", 32'(bus.instr_done), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    $display("instr op=000000 funct=%b aborted in RTYPEEX by reset", f);
  endtask

  function automatic logic [5:0] pick_funct();
    logic [5:0] tbl [5];
    tbl[0] = 6'b100000; tbl[1] = 6'b100010; tbl[2] = 6'b100100;
    tbl[3] = 6'b100101; tbl[4] = 6'b101010;
    if ($urandom_range(0, 3) == 0) return 6'($urandom_range(0, 63));
    return tbl[$urandom_range(0, 4)];
  endfunction

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 6))
      0: return 6'b100000;
      1: return 6'b101000;
      2: return 6'b000000;
      3: return 6'b000100;
      4: return 6'b000010;
      5: return 6'b001000;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    bus.op = 6'b0;
    bus.funct = 6'b0;
    bus.zero = 1'b0;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check_vec("rst state", 32'(bus.state), 32'd0);
      check_vec("rst pcen", 32'(bus.pcen), 32'd0);
      check_vec("rst irwrite", 32'(bus.irwrite), 32'd0);
      check_vec("rst memwrite", 32'(bus.memwrite), 32'd0);
      check_vec("rst regwrite", 32'(bus.regwrite), 32'd0);
      check_vec("rst done", 32'(bus.instr_done), 32'd0);
      check_vec("rst alusrcb", 32'(bus.alusrcb), 32'd1);
    end
    @(negedge clk);
    reset = 1'b1;

    run_instr(6'b000000, 6'b100010, 1'b0);
    run_instr(6'b000100, 6'b000000, 1'b1);
    run_instr(6'b000100, 6'b000000, 1'b0);
    run_instr(6'b100000, 6'b000000, 1'b0);
    run_instr(6'b101000, 6'b000000, 1'b0);
    run_instr(6'b001000, 6'b000000, 1'b0);
    run_instr(6'b111111, 6'b000000, 1'b0);
    run_instr(6'b000010, 6'b000000, 1'b1);
    abort_rtype(6'b101010);

    for (int n = 0; n < 60; n++) begin
      if (n == 30) abort_rtype(pick_funct());
      run_instr(pick_op(), pick_funct(), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "bench timed out");
  end

endmodule
